// File: rtl/spi_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sram_bridge
// Purpose  : Runs single 16-bit word read/write requests as one SPI mode-0
//            transaction each against a 23LC1024-class serial SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sram_bridge #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [47:0] r_frame;
  logic [47:0] w_frame_nxt;
  logic [47:0] w_frame_new;
  logic        r_is_read;
  logic [5:0]  r_bit_cnt;
  logic [3:0]  r_div_cnt;
  logic [15:0] r_rx;
  logic        w_div_end;
  logic        w_cs_n_nxt;
  logic        w_sck_nxt;
  logic        w_mosi_nxt;
  logic        w_ready_nxt;

  assign w_div_end   = (r_div_cnt == DIV_LAST);
  assign w_frame_new = {(mem_we ? CMD_WRITE : CMD_READ), 7'b0, mem_addr, 1'b0,
                        (mem_we ? mem_wdata : 16'h0000)};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (mem_req) w_state_nxt = S_SETUP;
      S_SETUP: if (w_div_end) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_div_end && !spi_sck && (r_bit_cnt == 6'd0)) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame shifts left on each SCK fall so bit 47 is always the bit on MOSI.
  always_comb begin
    w_frame_nxt = r_frame;
    if (r_state == S_IDLE && mem_req) begin
      w_frame_nxt = w_frame_new;
    end else if (r_state == S_SHIFT && w_div_end && spi_sck) begin
      w_frame_nxt = {r_frame[46:0], 1'b0};
    end
  end

  always_comb begin
    w_cs_n_nxt  = 1'b1;
    w_sck_nxt   = 1'b0;
    w_mosi_nxt  = 1'b0;
    w_ready_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE: w_ready_nxt = 1'b1;
      S_SETUP: begin
        w_cs_n_nxt = 1'b0;
        w_mosi_nxt = w_frame_nxt[47];
      end
      S_SHIFT: begin
        w_cs_n_nxt = 1'b0;
        w_mosi_nxt = w_frame_nxt[47];
        if (r_state == S_SETUP) begin
          w_sck_nxt = 1'b1;
        end else begin
          w_sck_nxt = w_div_end ? ~spi_sck : spi_sck;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame   <= '0;
      r_is_read <= 1'b0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_rx      <= '0;
      mem_rdata <= '0;
      mem_ready <= 1'b1;
      spi_cs_n  <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      r_frame   <= w_frame_nxt;
      mem_ready <= w_ready_nxt;
      spi_cs_n  <= w_cs_n_nxt;
      spi_sck   <= w_sck_nxt;
      spi_mosi  <= w_mosi_nxt;
      case (r_state)
        S_IDLE: begin
          if (mem_req) begin
            r_is_read <= ~mem_we;
            r_bit_cnt <= 6'd47;
            r_div_cnt <= '0;
          end
        end
        S_SETUP: begin
          r_div_cnt <= w_div_end ? 4'd0 : r_div_cnt + 4'd1;
          if (w_div_end) r_rx <= {r_rx[14:0], spi_miso};
        end
        S_SHIFT: begin
          r_div_cnt <= w_div_end ? 4'd0 : r_div_cnt + 4'd1;
          // A completed low phase starts the next bit with an SCK rise.
          if (w_div_end && !spi_sck && (r_bit_cnt != 6'd0)) begin
            r_bit_cnt <= r_bit_cnt - 6'd1;
            r_rx      <= {r_rx[14:0], spi_miso};
          end
        end
        default: begin
          if (r_is_read) mem_rdata <= r_rx;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sram_bridge
// Purpose  : Directed self-checking bench for spi_sram_bridge with a
//            behavioural SPI SRAM; covers CLK_DIV=1 and CLK_DIV=3 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_sram_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        sel = 1'b0;
  logic        miso = 1'b0;
  logic        garble = 1'b0;

  logic [15:0] rdata1, rdata3;
  logic        ready1, ready3, cs1, cs3, sck1, sck3, mosi1, mosi3;
  logic        req1, req3;

  logic [15:0] b_rdata;
  logic        b_ready, b_cs_n, b_sck, b_mosi;

  assign req1    = req & ~sel;
  assign req3    = req & sel;
  assign b_rdata = sel ? rdata3 : rdata1;
  assign b_ready = sel ? ready3 : ready1;
  assign b_cs_n  = sel ? cs3 : cs1;
  assign b_sck   = sel ? sck3 : sck1;
  assign b_mosi  = sel ? mosi3 : mosi1;

  always #5 clk = ~clk;

  spi_sram_bridge #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .mem_req(req1), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata1), .mem_ready(ready1), .spi_cs_n(cs1),
    .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso)
  );

  spi_sram_bridge #(.CLK_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .mem_req(req3), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata3), .mem_ready(ready3), .spi_cs_n(cs3),
    .spi_sck(sck3), .spi_mosi(mosi3), .spi_miso(miso)
  );

  // Behavioural 23LC1024: mode 0, MSB first, READ 0x03 / WRITE 0x02.
  logic [7:0]  sram [0:131071];
  logic [47:0] s_frame = '0;
  logic [47:0] last_frame = '0;
  logic [15:0] s_rd = '0;
  logic [16:0] s_a;
  int          s_cnt = 0;
  int          last_rises = 0;

  always @(negedge b_cs_n) begin
    s_cnt   = 0;
    s_frame = '0;
    miso    = 1'b0;
  end

  always @(posedge b_sck) begin
    if (!b_cs_n) begin
      s_frame = {s_frame[46:0], b_mosi};
      s_cnt   = s_cnt + 1;
      if (garble) miso = ~miso;
    end
  end

  always @(negedge b_sck) begin
    if (!b_cs_n) begin
      if (s_cnt == 32 && s_frame[31:24] == 8'h03) begin
        s_a  = s_frame[16:0];
        s_rd = {sram[s_a], sram[s_a + 17'd1]};
      end
      if (s_cnt >= 32 && s_cnt < 48) miso = s_rd[47 - s_cnt];
      else miso = 1'b0;
    end
  end

  always @(posedge b_cs_n) begin
    last_frame = s_frame;
    last_rises = s_cnt;
    if (s_cnt == 48 && s_frame[47:40] == 8'h02) begin
      sram[s_frame[32:16]]          = s_frame[15:8];
      sram[s_frame[32:16] + 17'd1]  = s_frame[7:0];
    end
  end

  // Per-cycle bus monitor: CS gaps and SCK phase widths inside a frame.
  int cs_hi_run = 0, gap_last = 0, cs_falls = 0;
  int run = 0, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
  logic prev_sck = 1'b0;

  task automatic record_run(input logic lvl, input int len);
    if (lvl) begin
      if (len < hi_min) hi_min = len;
      if (len > hi_max) hi_max = len;
    end else begin
      if (len < lo_min) lo_min = len;
      if (len > lo_max) lo_max = len;
    end
  endtask

  always @(negedge clk) begin
    if (b_cs_n) begin
      if (run > 0) record_run(prev_sck, run);
      run = 0;
      prev_sck = 1'b0;
      cs_hi_run = cs_hi_run + 1;
    end else begin
      if (cs_hi_run > 0) begin
        gap_last = cs_hi_run;
        cs_falls = cs_falls + 1;
      end
      cs_hi_run = 0;
      if (run == 0) begin
        prev_sck = b_sck;
        run = 1;
      end else if (b_sck == prev_sck) begin
        run = run + 1;
      end else begin
        record_run(prev_sck, run);
        prev_sck = b_sck;
        run = 1;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
  endtask

  task automatic start_txn(input logic t_we, input logic [15:0] t_addr, input logic [15:0] t_wd);
    int guard = 0;
    while (!b_ready && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wd;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_ready(input bit pulses, output int lat);
    lat = 0;
    while (!b_ready && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (pulses && (lat == 5 || lat == 40)) begin
        req = 1'b1; we = 1'b1; addr = 16'h5555; wdata = 16'h1111;
      end else begin
        req = 1'b0;
      end
    end
  endtask

  int lat;
  int falls0;
  int guard;

  initial begin
    sram[17'h1FFFE] = 8'hA5;
    sram[17'h1FFFF] = 8'hC3;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", b_ready, 1'b1);
    check("rst_cs_n", b_cs_n, 1'b1);
    check("rst_sck", b_sck, 1'b0);
    check("rst_mosi", b_mosi, 1'b0);
    check("rst_rdata", b_rdata, 16'h0000);

    // Write 0xBEEF to word 0x1234
    start_txn(1'b1, 16'h1234, 16'hBEEF);
    wait_ready(1'b0, lat);
    check("wr_frame", last_frame, 48'h02002468BEEF);
    check("wr_rises", last_rises, 48);
    check("wr_latency", lat, 98);
    check("wr_rdata", b_rdata, 16'h0000);
    check("wr_sram_hi", sram[17'h02468], 8'hBE);
    check("wr_sram_lo", sram[17'h02469], 8'hEF);

    // Read top word: address wraps to byte 0x1FFFE
    start_txn(1'b0, 16'hFFFF, 16'h0000);
    wait_ready(1'b0, lat);
    check("rd_frame", last_frame, 48'h0301FFFE0000);
    check("rd_rdata", b_rdata, 16'hA5C3);
    check("rd_latency", lat, 98);

    // Requests during a busy transaction must be dropped
    falls0 = cs_falls;
    start_txn(1'b0, 16'h1234, 16'h0000);
    wait_ready(1'b1, lat);
    repeat (5) @(posedge clk);
    #1;
    check("ign_frame", last_frame, 48'h030024680000);
    check("ign_cs_windows", cs_falls - falls0, 1);
    check("ign_rdata", b_rdata, 16'hBEEF);
    check("ign_latency", lat, 98);
    check("ign_idle_cs", b_cs_n, 1'b1);

    // Reset in the middle of a read
    start_txn(1'b0, 16'hFFFF, 16'h0000);
    guard = 0;
    while (s_cnt < 20 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_reached_bit20", (s_cnt >= 20), 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_cs_n", b_cs_n, 1'b1);
    check("abort_sck", b_sck, 1'b0);
    check("abort_ready", b_ready, 1'b1);
    check("abort_rdata", b_rdata, 16'h0000);
    start_txn(1'b0, 16'h1234, 16'h0000);
    wait_ready(1'b0, lat);
    check("post_abort_rdata", b_rdata, 16'hBEEF);
    check("post_abort_latency", lat, 98);

    // Held request: write 0x0001 to word 3 then read it back
    req = 1'b1; we = 1'b1; addr = 16'h0003; wdata = 16'h0001;
    @(posedge clk); #1;
    we = 1'b0; wdata = 16'h0000;
    guard = 0;
    while (!b_ready && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    req = 1'b0;
    wait_ready(1'b0, lat);
    check("b2b_rdata", b_rdata, 16'h0001);
    check("b2b_gap_ge2", (gap_last >= 2), 1'b1);
    check("b2b_sram", {sram[17'h6], sram[17'h7]}, 16'h0001);

    // CLK_DIV=3 instance, MISO scrambled while SCK is high
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b1;
    garble = 1'b1;
    clear_stats();
    start_txn(1'b0, 16'h0003, 16'h0000);
    wait_ready(1'b0, lat);
    check("div3_latency", lat, 292);
    check("div3_rdata", b_rdata, 16'h0001);
    check("div3_rises", last_rises, 48);
    check("div3_hi_min", hi_min, 3);
    check("div3_hi_max", hi_max, 3);
    check("div3_lo_min", lo_min, 3);
    check("div3_lo_max", lo_max, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_sram_bridge.md
# spi_sram_bridge

Responder side of the memory bus driven by the delay/reverb memory controller. It accepts single 16-bit word read/write requests (address, write-enable, write data) and executes each as one SPI transaction against an external 23LC1024-class serial SRAM. It returns read data and a ready flag, which feeds the controller's off-chip-memory-ready input. The bridge sits between the memory controller and the chip's SPI pads.

## Interface
- CLK_DIV, 1: SCK half-period in `clk` cycles; legal range 1..15.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- mem_req  input  1  request strobe; sampled only while `mem_ready`=1.
- mem_we  input  1  1 = write, 0 = read; sampled with `mem_req`.
- mem_addr  input  16  word address.
- mem_wdata  input  16  write data.
- mem_rdata  output  16  last completed read word.
- mem_ready  output  1  1 = idle and able to accept a request; also marks the result as valid.
- spi_cs_n  output  1  chip select, active-low.
- spi_sck  output  1  SPI clock, mode 0 (idles low).
- spi_mosi  output  1  serial data out, MSB first.
- spi_miso  input  1  serial data in.

## Operation
- States: IDLE, SETUP, SHIFT, DONE.
- IDLE: `mem_ready`=1, `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0.
  - On `mem_req`=1 the bridge latches a 48-bit frame and a direction flag, and goes to SETUP.
  - The frame is: command byte (0x02 for write, 0x03 for read), then 24-bit byte address {7'b0, mem_addr, 1'b0}, then 16 data bits.
  - The data field is `mem_wdata` for a write and zeros for a read.
- SETUP: `spi_cs_n`=0, `spi_sck`=0, `spi_mosi`=frame[47]. Lasts CLK_DIV cycles, then goes to SHIFT.
- SHIFT: 48 bits, each taking a high phase then a low phase of CLK_DIV cycles each.
  - `spi_miso` is sampled on the clk edge that drives `spi_sck` high.
  - `spi_mosi` advances to the next bit on the edge that drives `spi_sck` low.
  - A 6-bit bit counter and a 4-bit divider counter control the phases.
  - After the low phase of bit 0 the bridge goes to DONE.
- DONE, one cycle: `spi_cs_n`=1. For a read, `mem_rdata` takes the last 16 sampled MISO bits; the first sampled bit is the MSB, so the high byte at the even address comes first. Writes leave `mem_rdata` unchanged. Next state is IDLE.
- A `mem_req` while `mem_ready`=0 is ignored. It is not queued.
- Holding `mem_req`=1 gives back-to-back transactions, with `spi_cs_n` high for at least 2 cycles between them (DONE plus the IDLE accept cycle).
- Address wrap: `mem_addr`=0xFFFF maps to byte address 0x01FFFE. There is no other wrap logic.
- Reset in any state:
  - Next cycle: state IDLE, `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `mem_ready`=1, `mem_rdata`=0.
  - Any transaction in flight is aborted with no partial update of `mem_rdata`.
  - Reset takes priority over `mem_req` in the same cycle.

## Timing
- Reset values: `mem_rdata`=0, `mem_ready`=1, `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0.
- Request accepted at edge T, when `mem_req`=1 and `mem_ready`=1:
  - `mem_ready` falls and `spi_cs_n` falls after edge T.
  - First SCK rise occurs CLK_DIV cycles later.
- DONE is entered after edge T + CLK_DIV·97.
- `mem_ready`=1 returns, with `mem_rdata` valid, after edge T + CLK_DIV·97 + 1.
  - CLK_DIV=1 → 98 cycles.
  - CLK_DIV=3 → 292 cycles.
- `mem_rdata` is stable whenever `mem_ready`=1 and changes only in the DONE→IDLE transition of a read.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The controller runs ≤16 impulses per ADC sample with 2 accesses each. The team sizes CLK_DIV against the sample period using the latency figure above.

## Test plan
- Write, CLK_DIV=1, addr 0x1234, wdata 0xBEEF → SPI-slave model captures MOSI bytes 02 00 24 68 BE EF, with exactly 48 SCK rises while `spi_cs_n`=0; `mem_ready` is high again 98 cycles after accept; `mem_rdata` stays 0.
- Read, addr 0xFFFF, slave model drives 0xA5C3 on the data bits → MOSI bytes 03 01 FF FE; `mem_rdata`=0xA5C3 when `mem_ready` rises.
- CLK_DIV=3, read → SCK high/low phases are each 3 cycles; `mem_ready` returns after 292 cycles; data is sampled only on SCK rising edges.
- Pulse `mem_req` with new address/data at cycles 5 and 40 after accept → ignored; only one CS-low window and the original frame appear.
- Assert `reset` at bit 20 of a read → next cycle `spi_cs_n`=1, `spi_sck`=0, `mem_ready`=1, `mem_rdata`=0; a following read completes normally.
- `mem_req` held high, alternating write 0x0001→addr 3 and read addr 3 against a behavioural SRAM → read returns 0x0001, and `spi_cs_n` is high for ≥2 cycles between frames.
